// File: rtl/lfsr_bist_ctrl_if.sv
// BIST controller signal bundle: run control and status toward the test
// harness, plus the pattern/response path to the circuit under test.
//   master : test harness (drives Start, Abort and the CUT response)
//   slave  : the BIST controller
interface lfsr_bist_ctrl_if #(
    parameter int Length = 8
);
    logic            Start;
    logic            Abort;
    logic [1:Length] Resp;
    logic [1:Length] Pattern;
    logic            Pattern_valid;
    logic            Busy;
    logic            Done;
    logic            Pass;
    logic [1:Length] Signature;

    modport master (
        output Start, Abort, Resp,
        input  Pattern, Pattern_valid, Busy, Done, Pass, Signature
    );

    modport slave (
        input  Start, Abort, Resp,
        output Pattern, Pattern_valid, Busy, Done, Pass, Signature
    );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// LFSR-based BIST controller. A run walks the pattern generator through
// Num_Patterns states, compacts the CUT responses (one cycle behind their
// patterns) into a MISR, then reports Signature == Golden with a Done pulse.
// Done and Pass become visible the cycle after the REPORT state.
module lfsr_bist_ctrl #(
    parameter int              Length          = 8,
    parameter logic [1:Length] Seed            = 8'h91,
    parameter logic [1:Length] Tap_Coefficient = 8'b1100_1111,
    parameter int              Num_Patterns    = 255,
    parameter logic [1:Length] Golden          = 8'h00
) (
    input logic             Clock,
    input logic             Reset,
    lfsr_bist_ctrl_if.slave bist
);

    typedef enum logic [1:0] {
        s_idle,
        s_run,
        s_flush,
        s_report
    } state_t;

    // Value of the run counter during the final RUN cycle
    localparam logic [Length-1:0] last_count = Length'(Num_Patterns - 1);

    state_t            state;
    logic [1:Length]   pattern;
    logic [1:Length]   signature;
    logic [Length-1:0] count;
    logic              pattern_valid;
    logic              busy;
    logic              done;
    logic              pass;

    // One shift of the shared register structure: stage 1 takes the feedback
    // bit, every tapped later stage XORs it into its incoming value.
    function automatic logic [1:Length] lfsr_step(input logic [1:Length] y);
        logic [1:Length] nxt;
        nxt[1] = y[Length];
        for (int i = 2; i <= Length; i++) begin
            nxt[i] = y[i-1] ^ (Tap_Coefficient[Length-i+1] & y[Length]);
        end
        return nxt;
    endfunction

    // Run sequencer: state, generator, MISR, counter and all registered outputs
    always_ff @(posedge Clock) begin
        // NOTE: reset is synchronous, so it is just the first branch of the
        // clocked block; every register here uses <= so all of them sample
        // pre-edge values regardless of statement order.
        if (!Reset) begin
            state         <= s_idle;
            pattern       <= Seed;
            signature     <= '0;
            count         <= '0;
            pattern_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                s_idle: begin
                    if (bist.Start) begin
                        pattern       <= Seed;
                        signature     <= '0;
                        count         <= '0;
                        pass          <= 1'b0;
                        pattern_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= s_run;
                    end
                end
                s_run: begin
                    if (bist.Abort) begin
                        pattern_valid <= 1'b0;
                        busy          <= 1'b0;
                        pass          <= 1'b0;
                        state         <= s_idle;
                    end else begin
                        pattern <= lfsr_step(pattern);
                        count   <= count + 1'b1;
                        // The first RUN cycle carries no response yet
                        if (count != '0) begin
                            signature <= lfsr_step(signature) ^ bist.Resp;
                        end
                        if (count == last_count) begin
                            pattern_valid <= 1'b0;
                            state         <= s_flush;
                        end
                    end
                end
                s_flush: begin
                    busy <= 1'b0;
                    if (bist.Abort) begin
                        pass  <= 1'b0;
                        state <= s_idle;
                    end else begin
                        signature <= lfsr_step(signature) ^ bist.Resp;
                        state     <= s_report;
                    end
                end
                s_report: begin
                    done  <= 1'b1;
                    pass  <= (signature == Golden);
                    state <= s_idle;
                end
                default: state <= s_idle;
            endcase
        end
    end

    assign bist.Pattern       = pattern;
    assign bist.Pattern_valid = pattern_valid;
    assign bist.Busy          = busy;
    assign bist.Done          = done;
    assign bist.Pass          = pass;
    assign bist.Signature     = signature;

endmodule
